decode_stage: RTL and testbench

Registered, parametrised RV32I instruction decode stage sitting between the IF/ID register and the execute stage. It decodes one instruction per cycle into execute control fields and sign-extended immediates. It tracks in-flight destination registers in a small scoreboard, inserts bubbles on RAW hazards (load-use only when forwarding exists, any RAW otherwise), and supports valid/ready backpressure and branch flush.

---
 rtl/decode_stage.sv | 219 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32I decode stage with RAW scoreboard, bubble
//            insertion, valid/ready backpressure and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int PEND_DEPTH = 3,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic            out_func7b,
  output logic [2:0]      out_aluop,
  output logic [1:0]      out_alusrc,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_memtoreg,
  output logic            out_regwrite,
  output logic            out_jmp,
  output logic            out_illegal,
  output logic            stall
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_aluop;
  logic [1:0]      w_alusrc;
  logic            w_use_rs1, w_use_rs2;
  logic            w_memread, w_memwrite, w_memtoreg, w_regwrite, w_jmp, w_illegal;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_hazard, w_accept, w_head_valid;

  logic [PEND_DEPTH-1:0] r_sb_valid;
  logic [PEND_DEPTH-1:0] r_sb_regwrite;
  logic [PEND_DEPTH-1:0] r_sb_load;
  logic [4:0]            r_sb_rd [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] w_slot_hit;

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  // Unknown opcodes (including any word with instr[1:0] != 2'b11) fall to default.
  always_comb begin
    w_aluop    = 3'b000;
    w_alusrc   = 2'b00;
    w_imm32    = 32'd0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_jmp      = 1'b0;
    w_illegal  = 1'b0;
    case (in_instr[6:0])
      c_op_load: begin
        w_alusrc = 2'b01; w_imm32 = w_imm_i; w_use_rs1 = 1'b1;
        w_memread = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1;
      end
      c_op_store: begin
        w_alusrc = 2'b01; w_imm32 = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_memwrite = 1'b1;
      end
      c_op_branch: begin
        w_aluop = 3'b001; w_imm32 = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      c_op_reg: begin
        w_aluop = 3'b010; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_regwrite = 1'b1;
      end
      c_op_imm: begin
        w_aluop = 3'b011; w_alusrc = 2'b01; w_imm32 = w_imm_i; w_use_rs1 = 1'b1;
        w_regwrite = 1'b1;
      end
      c_op_lui: begin
        w_aluop = 3'b100; w_alusrc = 2'b01; w_imm32 = w_imm_u; w_regwrite = 1'b1;
      end
      c_op_auipc: begin
        w_aluop = 3'b101; w_alusrc = 2'b10; w_imm32 = w_imm_u; w_regwrite = 1'b1;
      end
      c_op_jal: begin
        w_aluop = 3'b110; w_alusrc = 2'b10; w_imm32 = w_imm_j; w_regwrite = 1'b1;
        w_jmp = 1'b1;
      end
      c_op_jalr: begin
        w_aluop = 3'b111; w_alusrc = 2'b01; w_imm32 = w_imm_i; w_use_rs1 = 1'b1;
        w_regwrite = 1'b1; w_jmp = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_sext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_direct
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  assign w_rs1 = w_use_rs1 ? in_instr[19:15] : 5'd0;
  assign w_rs2 = w_use_rs2 ? in_instr[24:20] : 5'd0;
  assign w_rd  = w_regwrite ? in_instr[11:7] : 5'd0;

  // With forwarding only a load still sitting in slot 0 cannot be bypassed.
  generate
    for (genvar gi = 0; gi < PEND_DEPTH; gi++) begin : g_slot
      logic w_rd_hit;
      assign w_rd_hit = r_sb_valid[gi] && r_sb_regwrite[gi] &&
                        (((w_rs1 != 5'd0) && (w_rs1 == r_sb_rd[gi])) ||
                         ((w_rs2 != 5'd0) && (w_rs2 == r_sb_rd[gi])));
      assign w_slot_hit[gi] = w_rd_hit &&
                              (FWD_EN ? ((gi == 0) && r_sb_load[gi]) : 1'b1);
    end
  endgenerate

  assign w_hazard     = |w_slot_hit;
  assign stall        = in_valid && w_hazard;
  assign in_ready     = (!out_valid || out_ready) && !stall && !flush;
  assign w_accept     = in_valid && in_ready;
  // A flushed head entry moves downstream as invalid so it never hazards later.
  assign w_head_valid = r_sb_valid[0] && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1       <= 5'd0;
      out_rs2       <= 5'd0;
      out_rd        <= 5'd0;
      out_func3     <= 3'd0;
      out_func7b    <= 1'b0;
      out_aluop     <= 3'd0;
      out_alusrc    <= 2'd0;
      out_memread   <= 1'b0;
      out_memwrite  <= 1'b0;
      out_memtoreg  <= 1'b0;
      out_regwrite  <= 1'b0;
      out_jmp       <= 1'b0;
      out_illegal   <= 1'b0;
      r_sb_valid    <= '0;
      r_sb_regwrite <= '0;
      r_sb_load     <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) begin
        r_sb_rd[i] <= 5'd0;
      end
    end else begin
      if (out_ready) begin
        for (int i = 1; i < PEND_DEPTH; i++) begin
          r_sb_valid[i]    <= (i == 1) ? w_head_valid : r_sb_valid[i-1];
          r_sb_regwrite[i] <= r_sb_regwrite[i-1];
          r_sb_load[i]     <= r_sb_load[i-1];
          r_sb_rd[i]       <= r_sb_rd[i-1];
        end
      end
      if (flush) begin
        out_valid     <= 1'b0;
        r_sb_valid[0] <= 1'b0;
      end else if (w_accept) begin
        out_valid        <= 1'b1;
        out_pc           <= in_pc;
        out_imm          <= w_imm;
        out_rs1          <= w_rs1;
        out_rs2          <= w_rs2;
        out_rd           <= w_rd;
        out_func3        <= in_instr[14:12];
        out_func7b       <= in_instr[30];
        out_aluop        <= w_aluop;
        out_alusrc       <= w_alusrc;
        out_memread      <= w_memread;
        out_memwrite     <= w_memwrite;
        out_memtoreg     <= w_memtoreg;
        out_regwrite     <= w_regwrite;
        out_jmp          <= w_jmp;
        out_illegal      <= w_illegal;
        r_sb_valid[0]    <= 1'b1;
        r_sb_regwrite[0] <= w_regwrite;
        r_sb_load[0]     <= w_memread;
        r_sb_rd[0]       <= w_rd;
      end else if (out_ready) begin
        out_valid     <= 1'b0;
        r_sb_valid[0] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Scoreboard bench for decode_stage, with and without forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic        func7b;
    logic [2:0]  aluop;
    logic [1:0]  alusrc;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic        jmp;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_flush, a_out_ready, a_out_valid, a_stall;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
  logic [2:0]  a_out_func3, a_out_aluop;
  logic [1:0]  a_out_alusrc;
  logic        a_out_func7b, a_out_memread, a_out_memwrite, a_out_memtoreg;
  logic        a_out_regwrite, a_out_jmp, a_out_illegal;

  logic        b_in_valid, b_in_ready, b_flush, b_out_ready, b_out_valid, b_stall;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [2:0]  b_out_func3, b_out_aluop;
  logic [1:0]  b_out_alusrc;
  logic        b_out_func7b, b_out_memread, b_out_memwrite, b_out_memtoreg;
  logic        b_out_regwrite, b_out_jmp, b_out_illegal;

  decode_stage #(.XLEN(32), .PEND_DEPTH(3), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(a_flush), .out_ready(a_out_ready),
    .out_valid(a_out_valid), .out_pc(a_out_pc), .out_imm(a_out_imm),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd),
    .out_func3(a_out_func3), .out_func7b(a_out_func7b), .out_aluop(a_out_aluop),
    .out_alusrc(a_out_alusrc), .out_memread(a_out_memread), .out_memwrite(a_out_memwrite),
    .out_memtoreg(a_out_memtoreg), .out_regwrite(a_out_regwrite), .out_jmp(a_out_jmp),
    .out_illegal(a_out_illegal), .stall(a_stall)
  );

  decode_stage #(.XLEN(32), .PEND_DEPTH(3), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush), .out_ready(b_out_ready),
    .out_valid(b_out_valid), .out_pc(b_out_pc), .out_imm(b_out_imm),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd),
    .out_func3(b_out_func3), .out_func7b(b_out_func7b), .out_aluop(b_out_aluop),
    .out_alusrc(b_out_alusrc), .out_memread(b_out_memread), .out_memwrite(b_out_memwrite),
    .out_memtoreg(b_out_memtoreg), .out_regwrite(b_out_regwrite), .out_jmp(b_out_jmp),
    .out_illegal(b_out_illegal), .stall(b_stall)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_exp, mon_obs;

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '0;
    e.pc = pc; e.func3 = i[14:12]; e.func7b = i[30];
    case (i[6:0])
      7'h03: begin e.alusrc = 2'd1; e.regwrite = 1; e.memread = 1; e.memtoreg = 1;
                   e.imm = imm_i; e.rs1 = i[19:15]; e.rd = i[11:7]; end
      7'h23: begin e.alusrc = 2'd1; e.memwrite = 1; e.imm = imm_s;
                   e.rs1 = i[19:15]; e.rs2 = i[24:20]; end
      7'h63: begin e.aluop = 3'd1; e.imm = imm_b; e.rs1 = i[19:15]; e.rs2 = i[24:20]; end
      7'h33: begin e.aluop = 3'd2; e.regwrite = 1; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                   e.rd = i[11:7]; end
      7'h13: begin e.aluop = 3'd3; e.alusrc = 2'd1; e.regwrite = 1; e.imm = imm_i;
                   e.rs1 = i[19:15]; e.rd = i[11:7]; end
      7'h37: begin e.aluop = 3'd4; e.alusrc = 2'd1; e.regwrite = 1; e.imm = imm_u;
                   e.rd = i[11:7]; end
      7'h17: begin e.aluop = 3'd5; e.alusrc = 2'd2; e.regwrite = 1; e.imm = imm_u;
                   e.rd = i[11:7]; end
      7'h6F: begin e.aluop = 3'd6; e.alusrc = 2'd2; e.regwrite = 1; e.jmp = 1;
                   e.imm = imm_j; e.rd = i[11:7]; end
      7'h67: begin e.aluop = 3'd7; e.alusrc = 2'd1; e.regwrite = 1; e.jmp = 1;
                   e.imm = imm_i; e.rs1 = i[19:15]; e.rd = i[11:7]; end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  // Every transfer into execute must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got pc=%h rd=%0d with nothing expected", a_out_pc, a_out_rd);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_obs = '{pc: a_out_pc, imm: a_out_imm, rs1: a_out_rs1, rs2: a_out_rs2,
                    rd: a_out_rd, func3: a_out_func3, func7b: a_out_func7b,
                    aluop: a_out_aluop, alusrc: a_out_alusrc, memread: a_out_memread,
                    memwrite: a_out_memwrite, memtoreg: a_out_memtoreg,
                    regwrite: a_out_regwrite, jmp: a_out_jmp, illegal: a_out_illegal};
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL issue_fields: got %h want %h", mon_obs, mon_exp);
        end
      end
    end
  end

  // Present one instruction and wait for it to be accepted; returns stall cycles.
  task automatic send_a(input logic [31:0] instr, input logic [31:0] pc, output int waited);
    a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = pc;
    exp_q.push_back(ref_decode(instr, pc));
    waited = 0;
    forever begin
      @(negedge clk);
      if (a_in_ready === 1'b1) break;
      waited++;
      if (waited > 40) begin
        checks++; errors++;
        $display("FAIL send_timeout: instr %h not accepted after %0d cycles", instr, waited);
        break;
      end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_imm !== 32'd0 || a_out_rd !== 5'd0) begin errors++; $display("FAIL rst_fields: got imm=%h rd=%0d want 0", a_out_imm, a_out_rd); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b want 0", b_out_valid); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || a_stall !== 1'b0) begin errors++; $display("FAIL rst_ready: got ready=%b stall=%b want 1/0", a_in_ready, a_stall); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %b want 1", b_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    int w;
    send_a(32'h0000A283, 32'h0000_0010, w);            // lw x5,0(x1)
    a_in_valid = 1'b1; a_in_instr = 32'h00228333; a_in_pc = 32'h0000_0014;  // add x6,x5,x2
    exp_q.push_back(ref_decode(32'h00228333, 32'h0000_0014));
    @(negedge clk);
    checks++; if (a_stall !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got stall=%b ready=%b want 1/0", a_stall, a_in_ready); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got out_valid=%b want 0", a_out_valid); end
    checks++; if (a_stall !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got stall=%b ready=%b want 0/1", a_stall, a_in_ready); end
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_rs1 !== 5'd5 || a_out_rs2 !== 5'd2 || a_out_aluop !== 3'b010)
      begin errors++; $display("FAIL lu_add: got v=%b rs1=%0d rs2=%0d aluop=%b want 1/5/2/010", a_out_valid, a_out_rs1, a_out_rs2, a_out_aluop); end
    @(posedge clk); #1;
  endtask

  task automatic test_nofwd_raw();
    int  bubbles = 0;
    bit  found = 0;
    bit  acc;
    b_in_valid = 1'b1; b_in_instr = 32'h00100193; b_in_pc = 32'h0000_0100;  // addi x3,x0,1
    @(negedge clk);
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL nf_accept: got %b want 1", b_in_ready); end
    @(posedge clk); #1;
    b_in_instr = 32'h40318233; b_in_pc = 32'h0000_0104;                       // sub x4,x3,x3
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_out_valid === 1'b1 && b_out_rd === 5'd4) begin found = 1; break; end
      if (b_out_valid !== 1'b1) bubbles++;
      acc = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (acc) b_in_valid = 1'b0;
    end
    checks++; if (!found) begin errors++; $display("FAIL nf_timeout: sub never issued, got found=0 want 1"); end
    checks++; if (bubbles != 3) begin errors++; $display("FAIL nf_bubbles: got %0d want 3", bubbles); end
    checks++; if (b_out_func7b !== 1'b1 || b_out_rs1 !== 5'd3 || b_out_rs2 !== 5'd3 || b_out_aluop !== 3'b010)
      begin errors++; $display("FAIL nf_sub: got f7b=%b rs1=%0d rs2=%0d aluop=%b want 1/3/3/010", b_out_func7b, b_out_rs1, b_out_rs2, b_out_aluop); end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_immediates();
    int w;
    send_a(32'hFE000EE3, 32'h0000_0200, w);            // beq x0,x0,-4
    @(negedge clk);
    checks++; if (a_out_imm !== 32'hFFFFFFFC || a_out_aluop !== 3'b001)
      begin errors++; $display("FAIL imm_beq: got imm=%h aluop=%b want fffffffc/001", a_out_imm, a_out_aluop); end
    @(posedge clk); #1;
    send_a(32'h800000EF, 32'h0000_0204, w);            // jal x1,-1MiB
    @(negedge clk);
    checks++; if (a_out_imm !== 32'hFFF00000 || a_out_rd !== 5'd1 || a_out_jmp !== 1'b1 || a_out_regwrite !== 1'b1)
      begin errors++; $display("FAIL imm_jal: got imm=%h rd=%0d jmp=%b rw=%b want fff00000/1/1/1", a_out_imm, a_out_rd, a_out_jmp, a_out_regwrite); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [6];
    int w;
    prog = '{32'h123455B7, 32'h00001617, 32'hFE20AC23, 32'h004280E7, 32'h00500393, 32'h00208433};
    for (int i = 0; i < 6; i++) begin
      send_a(prog[i], 32'h0000_0300 + 32'(i * 4), w);
      checks++; if (w != 0) begin errors++; $display("FAIL b2b_stall[%0d]: got %0d stall cycles want 0", i, w); end
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int w;
    send_a(32'h00500393, 32'h0000_0400, w);            // addi x7,x0,5
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h00208433; a_in_pc = 32'h0000_0404;  // add x8,x1,x2
    exp_q.push_back(ref_decode(32'h00208433, 32'h0000_0404));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd7 || a_out_pc !== 32'h0000_0400 || a_in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b rd=%0d pc=%h ready=%b want 1/7/400/0", c, a_out_valid, a_out_rd, a_out_pc, a_in_ready); end
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ready=%b want 1", a_in_ready); end
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_rd !== 5'd8) begin errors++; $display("FAIL bp_next: got rd=%0d want 8", a_out_rd); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got out_valid=%b want 0", a_out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int w;
    exp_t dead;
    send_a(32'h0000A483, 32'h0000_0500, w);            // lw x9,0(x1)
    a_flush = 1'b1; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h00048533; a_in_pc = 32'h0000_0504;  // add x10,x9,x0
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin errors++; $display("FAIL fl_cycle: got ready=%b v=%b want 0/1", a_in_ready, a_out_valid); end
    @(posedge clk); #1;
    a_flush = 1'b0; a_out_ready = 1'b1;
    dead = exp_q.pop_front();
    exp_q.push_back(ref_decode(32'h00048533, 32'h0000_0504));
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_killed: got out_valid=%b want 0", a_out_valid); end
    checks++; if (a_stall !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL fl_nostall: got stall=%b ready=%b want 0/1", a_stall, a_in_ready); end
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd10) begin errors++; $display("FAIL fl_dep: got v=%b rd=%0d want 1/10", a_out_valid, a_out_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int w;
    send_a(32'h00000000, 32'h0000_0600, w);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_illegal !== 1'b1 || a_out_memwrite !== 1'b0 || a_out_regwrite !== 1'b0)
      begin errors++; $display("FAIL illegal: got v=%b ill=%b mw=%b rw=%b want 1/1/0/0", a_out_valid, a_out_illegal, a_out_memwrite, a_out_regwrite); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    int w;
    send_a(32'h0000A283, 32'h0000_0700, w);            // lw x5,0(x1)
    a_in_valid = 1'b1; a_in_instr = 32'h00228333; a_in_pc = 32'h0000_0704;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL rs_stall: got %b want 1", a_stall); end
    #2 reset = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0 || a_out_memread !== 1'b0 || a_out_pc !== 32'd0)
      begin errors++; $display("FAIL rs_async: got v=%b rd=%0d mr=%b pc=%h want all 0", a_out_valid, a_out_rd, a_out_memread, a_out_pc); end
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    exp_q.push_back(ref_decode(32'h00228333, 32'h0000_0704));
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || a_stall !== 1'b0) begin errors++; $display("FAIL rs_ready: got ready=%b stall=%b want 1/0", a_in_ready, a_stall); end
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rs_issue: got out_valid=%b want 1", a_out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    a_in_valid = 0; a_in_instr = 0; a_in_pc = 0; a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_flush = 0; b_out_ready = 1;
    test_reset();
    test_load_use();
    test_nofwd_raw();
    test_immediates();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
